// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: fetch constants, fetch FSM states, IF/ID record.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [31:0] PC_INC    = 32'd4;

    typedef enum logic {
        FS_RUN,
        FS_HALT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_pc_next_sel.sv
// Combinational next-PC priority mux (branch > jump > stall > PC+4) and fetch range check.
module pc_next_sel
    import mips_pkg::*;
#(
    parameter int unsigned IM_AW = 5
) (
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc_next,
    output logic        redirect,
    output logic        pc_bad
);

    // Priority select of the next PC plus out-of-range / misaligned detection
    always_comb begin
        pc_plus4 = pc + PC_INC;
        redirect = br_taken | jump;
        pc_bad   = (|pc[31:IM_AW+2]) | (|pc[1:0]);
        if (br_taken) begin
            pc_next = br_target;
        end else if (jump) begin
            pc_next = jump_target;
        end else if (stall) begin
            pc_next = pc;
        end else begin
            pc_next = pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IM word pointer, IF/ID register, RUN/HALT control.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned IM_AW    = 5,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IM_AW-1:0] im_addr_o,
    input  logic [31:0]      im_instr_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             br_taken_i,
    input  logic [31:0]      br_target_i,
    input  logic             jump_i,
    input  logic [31:0]      jump_target_i,
    output logic [31:0]      ifid_instr_o,
    output logic [31:0]      ifid_pc4_o,
    output logic             ifid_valid_o,
    output logic             halted_o
);

    localparam ifid_t BUBBLE = '{instr: NOP, pc4: 32'h0, valid: 1'b0};

    fetch_state_t state;
    logic [31:0]  pc;
    ifid_t        ifid;
    logic         halted;

    logic [31:0]  pc_plus4;
    logic [31:0]  pc_next;
    logic         redirect;
    logic         pc_bad;

    pc_next_sel #(
        .IM_AW (IM_AW)
    ) u_pc_next_sel (
        .pc          (pc),
        .stall       (stall_i),
        .br_taken    (br_taken_i),
        .br_target   (br_target_i),
        .jump        (jump_i),
        .jump_target (jump_target_i),
        .pc_plus4    (pc_plus4),
        .pc_next     (pc_next),
        .redirect    (redirect),
        .pc_bad      (pc_bad)
    );

    // Fetch FSM: PC, IF/ID register and halt flag; HALT is sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FS_RUN;
            pc     <= RESET_PC;
            ifid   <= BUBBLE;
            halted <= 1'b0;
        end else begin
            case (state)
                FS_RUN: begin
                    if (redirect) begin
                        // a redirect wins over stall and over a bad current PC
                        pc   <= pc_next;
                        ifid <= BUBBLE;
                    end else if (pc_bad) begin
                        state  <= FS_HALT;
                        halted <= 1'b1;
                        ifid   <= BUBBLE;
                    end else begin
                        pc <= pc_next;
                        if (flush_i) begin
                            ifid <= BUBBLE;
                        end else if (!stall_i) begin
                            ifid <= '{instr: im_instr_i, pc4: pc_plus4, valid: 1'b1};
                        end
                    end
                end
                FS_HALT: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        im_addr_o    = pc[IM_AW+1:2];
        ifid_instr_o = ifid.instr;
        ifid_pc4_o   = ifid.pc4;
        ifid_valid_o = ifid.valid;
        halted_o     = halted;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations,
// then randomized redirect/stall/flush/reset traffic checked against a behavioural model.
module tb_fetch_stage;

    localparam int unsigned IM_AW    = 5;
    localparam int unsigned IM_WORDS = 32;
    localparam logic [31:0] MEM_END  = 32'd128;  // first byte address past memory

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [IM_AW-1:0] im_addr;
    logic [31:0]      im_instr;
    logic             stall, flush, br_taken, jump;
    logic [31:0]      br_target, jump_target;
    logic [31:0]      ifid_instr, ifid_pc4;
    logic             ifid_valid, halted;

    logic [31:0] mem [IM_WORDS];

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    bit          check_en   = 1'b0;

    always #5 clk = ~clk;

    assign im_instr = mem[im_addr];

    fetch_stage #(
        .IM_AW    (IM_AW),
        .RESET_PC (32'h0000_0000),
        .NOP      (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .im_addr_o     (im_addr),
        .im_instr_i    (im_instr),
        .stall_i       (stall),
        .flush_i       (flush),
        .br_taken_i    (br_taken),
        .br_target_i   (br_target),
        .jump_i        (jump),
        .jump_target_i (jump_target),
        .ifid_instr_o  (ifid_instr),
        .ifid_pc4_o    (ifid_pc4),
        .ifid_valid_o  (ifid_valid),
        .halted_o      (halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: program counter as a byte address, IF/ID as plain fields
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halted;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 0; m_instr <= 0; m_pc4 <= 0; m_valid <= 0; m_halted <= 0;
        end else if (!m_halted) begin
            if (br_taken || jump) begin
                m_pc    <= br_taken ? br_target : jump_target;
                m_instr <= 0; m_pc4 <= 0; m_valid <= 0;
            end else if (m_pc >= MEM_END || (m_pc % 4) != 0) begin
                m_halted <= 1;
                m_instr <= 0; m_pc4 <= 0; m_valid <= 0;
            end else begin
                if (flush) begin
                    m_instr <= 0; m_pc4 <= 0; m_valid <= 0;
                end else if (!stall) begin
                    m_instr <= mem[m_pc / 4];
                    m_pc4   <= m_pc + 4;
                    m_valid <= 1;
                end
                if (!stall) m_pc <= m_pc + 4;
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            check("im_addr",    32'(im_addr),    (m_pc / 4) % IM_WORDS);
            check("ifid_instr", ifid_instr,      m_instr);
            check("ifid_pc4",   ifid_pc4,        m_pc4);
            check("ifid_valid", 32'(ifid_valid), 32'(m_valid));
            check("halted",     32'(halted),     32'(m_halted));
        end
    end

    task automatic clear_inputs();
        stall = 0; flush = 0; br_taken = 0; jump = 0; br_target = 0; jump_target = 0;
    endtask

    initial begin
        clear_inputs();
        for (int i = 0; i < IM_WORDS; i++) mem[i] = 32'(i);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_en = 1'b1;

        // reset state
        check("rst_addr",  32'(im_addr),    32'd0);
        check("rst_valid", 32'(ifid_valid), 32'd0);
        check("rst_pc4",   ifid_pc4,        32'd0);
        check("rst_halt",  32'(halted),     32'd0);

        // sequential fetch
        @(negedge clk);
        check("seq1_addr", 32'(im_addr), 32'd1);
        check("seq1_pc4",  ifid_pc4,     32'd4);
        check("seq1_val",  32'(ifid_valid), 32'd1);
        @(negedge clk);
        check("seq2_addr",  32'(im_addr), 32'd2);
        check("seq2_instr", ifid_instr,   32'd1);
        check("seq2_pc4",   ifid_pc4,     32'd8);

        // stall at PC=8
        stall = 1;
        repeat (3) begin
            @(negedge clk);
            check("stall_addr",  32'(im_addr),    32'd2);
            check("stall_instr", ifid_instr,      32'd1);
            check("stall_valid", 32'(ifid_valid), 32'd1);
        end
        stall = 0;
        @(negedge clk);
        check("resume_addr", 32'(im_addr), 32'd3);
        check("resume_pc4",  ifid_pc4,     32'd12);
        @(negedge clk);
        check("pc16_addr", 32'(im_addr), 32'd4);

        // redirect priority: branch beats jump and stall
        br_taken = 1; br_target = 32'd40; jump = 1; jump_target = 32'd60; stall = 1;
        @(negedge clk);
        clear_inputs();
        check("redir_addr",  32'(im_addr),    32'd10);
        check("redir_valid", 32'(ifid_valid), 32'd0);
        @(negedge clk);
        check("redir_instr", ifid_instr,      32'd10);
        check("redir_pc4",   ifid_pc4,        32'd44);
        check("redir_val2",  32'(ifid_valid), 32'd1);

        // flush without redirect
        flush = 1;
        @(negedge clk);
        flush = 0;
        check("flush_addr",  32'(im_addr),    32'd12);
        check("flush_valid", 32'(ifid_valid), 32'd0);
        check("flush_instr", ifid_instr,      32'd0);

        // run off the end of memory
        for (int k = 0; k < 40 && m_pc != 32'd124; k++) @(negedge clk);
        check("reach_124", m_pc, 32'd124);
        @(negedge clk);
        check("end_instr", ifid_instr,   32'd31);
        check("end_pc4",   ifid_pc4,     32'd128);
        check("end_halt0", 32'(halted),  32'd0);
        @(negedge clk);
        check("halt_rise",  32'(halted),     32'd1);
        check("halt_valid", 32'(ifid_valid), 32'd0);
        check("halt_addr",  32'(im_addr),    32'd0);
        repeat (4) begin
            br_taken = 1; br_target = 32'd8; flush = 1; stall = 1;
            @(negedge clk);
            check("halt_sticky", 32'(halted),  32'd1);
            check("halt_frozen", 32'(im_addr), 32'd0);
        end
        clear_inputs();

        // asynchronous reset while halted
        #2 rst_n = 1'b0;
        #1;
        check("arst_halt",  32'(halted),     32'd0);
        check("arst_valid", 32'(ifid_valid), 32'd0);
        check("arst_addr",  32'(im_addr),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart_addr", 32'(im_addr), 32'd1);
        check("restart_pc4",  ifid_pc4,     32'd4);

        // randomized traffic
        for (int i = 0; i < IM_WORDS; i++) mem[i] = $urandom;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            br_taken = ($urandom_range(0, 9) == 0);
            jump     = ($urandom_range(0, 9) == 0);
            br_target   = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 31)) * 4;
            jump_target = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 31)) * 4;
            if ($urandom_range(0, 39) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                check("rand_arst_valid", 32'(ifid_valid), 32'd0);
                check("rand_arst_halt",  32'(halted),     32'd0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        clear_inputs();
        @(negedge clk);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS datapath. Holds the program counter, drives the word pointer into the combinational instruction memory, and selects the next PC from sequential, branch or jump sources. Captures the fetched word into an IF/ID pipeline register for the decode stage. Supports stall, flush and an out-of-range halt.

## Interface

- `IM_AW`, 5: instruction-memory word-address width (32 words).
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; must be word aligned.
- `NOP`, 32'h0000_0000: word inserted into IF/ID on flush or bubble.

Ports (one clock; reset is asynchronous and active-low):

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `im_addr_o`  out  IM_AW  word pointer to instruction memory; `pc[IM_AW+1:2]`.
- `im_instr_i`  in  32  instruction returned combinationally by instruction memory.
- `stall_i`  in  1  hold PC and IF/ID (hazard unit).
- `flush_i`  in  1  replace the IF/ID contents with NOP, valid=0.
- `br_taken_i`  in  1  branch resolved taken (EX stage).
- `br_target_i`  in  32  branch target byte address.
- `jump_i`  in  1  jump decoded (ID stage).
- `jump_target_i`  in  32  jump target byte address.
- `ifid_instr_o`  out  32  registered instruction.
- `ifid_pc4_o`  out  32  registered PC+4 of that instruction.
- `ifid_valid_o`  out  1  IF/ID holds a real instruction.
- `halted_o`  out  1  fetch stopped on an out-of-range or misaligned PC.

## Operation

- FSM states are RUN and HALT. Reset enters RUN.
- RUN, next-PC priority:
  - `br_taken_i`: `br_target_i`.
  - else `jump_i`: `jump_target_i`.
  - else `stall_i`: hold.
  - else PC+4, mod 2^32.
- A redirect (branch or jump) overrides `stall_i`, so a stall never blocks a redirect.
- IF/ID update rules:
  - `flush_i`, or any redirect: load NOP, pc4=0, valid=0.
  - else `stall_i`: hold.
  - else load `im_instr_i`, PC+4, valid=1.
- Range check:
  - If the PC to be fetched has `pc[31:IM_AW+2]` nonzero or `pc[1:0]` nonzero, do not capture it.
  - Instead go to HALT and load a bubble into IF/ID.
  - A redirect in that same cycle takes priority: load the target and stay in RUN.
- HALT:
  - PC frozen, IF/ID fixed at bubble, `halted_o`=1.
  - HALT is left only by reset. Redirect, stall and flush inputs are ignored.
- There is no wrap-around inside memory. PC+4 past word 2^IM_AW−1 becomes an out-of-range PC, which halts fetch.
- Branch/jump targets are taken as given. Validation happens only through the range check on the following fetch.
- `NOP` is all-zero (sll $0,$0,0). Decode treats valid=0 as a bubble regardless of the instruction word.

## Timing

- `im_addr_o` is combinational from the PC register, so instruction-memory data for the current PC arrives in the same cycle.
- Fetch-to-IF/ID latency is one cycle. An instruction at PC appears on `ifid_*` after the rising edge that ends its fetch cycle.
- A redirect asserted in cycle N:
  - the target is fetched in cycle N+1;
  - IF/ID holds a bubble during N+1;
  - the target instruction is valid in IF/ID from N+2.
- Reset values:
  - `pc` = `RESET_PC`, so `im_addr_o` = `RESET_PC[IM_AW+1:2]`.
  - `ifid_instr_o` = NOP, `ifid_pc4_o` = 0, `ifid_valid_o` = 0, `halted_o` = 0, state = RUN.
- Reset asserted mid-operation returns all state to reset values immediately, asynchronously. The first fetch after deassertion is `RESET_PC`.
- `halted_o` is registered. It rises on the edge that enters HALT.

## Structure

- Shared package `mips_pkg` holds:
  - `NOP_INSTR`, `PC_INC` (4);
  - the fetch FSM enum {`FS_RUN`, `FS_HALT`};
  - typedef `ifid_t` {instr, pc4, valid}, reused by decode.
- One natural sub-module, `pc_next_sel`: purely combinational next-PC priority mux and range check, which the FSM and registers wrap.
- Target size is about 150–250 lines of RTL including the sub-module.

## Test plan

- **Reset and sequential fetch.** Stimulus: hold `rst_n`=0 for 2 cycles, release; memory returns word index as data. Required: `im_addr_o` = 0,1,2,3 on successive cycles; `ifid_instr_o` lags by one cycle with valid=1; `ifid_pc4_o` = 4,8,12.
- **Stall.** Stimulus: `stall_i`=1 for 3 cycles at PC=8. Required: `im_addr_o` stays 2; IF/ID holds the word from PC=4 with valid=1; fetch resumes at PC=12 after release.
- **Redirect priority.** Stimulus: at PC=16, assert `br_taken_i` (target 40), `jump_i` (target 60) and `stall_i` together. Required: next `im_addr_o`=10; IF/ID is a bubble for one cycle; word 10 is valid the following cycle.
- **Flush without redirect.** Stimulus: `flush_i`=1 for one cycle. Required: IF/ID = NOP/valid=0; PC still advances by 4.
- **Run-off-end halt.** Stimulus: sequential fetch past word 31. Required: after fetching PC=124, `halted_o`=1; PC frozen at 128; stall, flush and branch inputs then have no effect.
- **Mid-run reset.** Stimulus: assert `rst_n`=0 between clock edges while in HALT. Required: `halted_o`=0 and valid=0 immediately; fetch restarts at `RESET_PC`.
